// File: rtl/rot_seq_pkg.sv
// rtl/rot_seq_pkg.sv - shared CPU datapath constants and rotate sequencer state encoding
package rot_seq_pkg;

    // Datapath width shared by the shift unit, ALU and rotate sequencer
    localparam int DATA_W = 8;

    // Rotate direction encoding for the dir input
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rot_seq.sv
// rtl/rot_seq.sv - multi-cycle rotate sequencer driving the combinational shift unit
module rot_seq
    import rot_seq_pkg::*;
#(
    parameter int DATA_W = rot_seq_pkg::DATA_W,
    parameter int AMT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [AMT_W-1:0]  amt,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              cf_out,
    output logic [DATA_W-1:0] sh_a,
    output logic              fbus,
    output logic              frbus,
    output logic              flbus,
    input  logic [DATA_W-1:0] sh_w,
    input  logic              sh_cf
);

    state_t            state;
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  cnt;
    logic              dir_r;
    logic              cf;

    // The data register feeds the shift unit and is the visible result
    assign sh_a   = data;
    assign dout   = data;
    assign cf_out = cf;

    // Sequencer FSM; selects, busy and done are registered alongside the state
    // so they change only on the clock edge that enters the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            data  <= '0;
            cnt   <= '0;
            dir_r <= DIR_RIGHT;
            cf    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            fbus  <= 1'b0;
            frbus <= 1'b0;
            flbus <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data  <= din;
                        cnt   <= amt;
                        dir_r <= dir;
                        busy  <= 1'b1;
                        if (amt == '0) begin
                            // Zero rotation still makes one pass through the shift unit
                            state <= ST_PASS;
                            fbus  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            frbus <= (dir == DIR_RIGHT);
                            flbus <= (dir == DIR_LEFT);
                        end
                    end
                end
                ST_PASS: begin
                    data  <= sh_w;
                    cf    <= 1'b0;
                    fbus  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_SHIFT: begin
                    data <= sh_w;
                    cf   <= sh_cf;
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        // Last rotation: drop the select before the result is flagged
                        frbus <= 1'b0;
                        flbus <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        frbus <= (dir_r == DIR_RIGHT);
                        flbus <= (dir_r == DIR_LEFT);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rot_seq.md
# rot_seq

Multi-cycle rotate sequencer that sits directly around the 8-bit combinational shift unit in the CPU datapath.
- Upstream role: drives the shift unit's operand and its `fbus`/`flbus`/`frbus` selects.
- Downstream role: latches the shift unit's `w`/`cf` back into its own data register, repeating once per cycle to rotate by 0–7 positions.
- Lets the control unit issue a single "rotate by N" request instead of sequencing N single-bit shifts itself.

## Interface
Parameters:
- `DATA_W`, 8: datapath width; must equal the shift unit width (8).
- `AMT_W`, 3: width of the rotate amount.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `dir` in 1: 0 = rotate right, 1 = rotate left; sampled with `start`.
- `amt` in AMT_W: number of 1-bit rotations; sampled with `start`.
- `din` in DATA_W: operand; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until DONE is left.
- `done` out 1: one-cycle pulse; `dout`/`cf_out` are valid from this cycle on.
- `dout` out DATA_W: result register; held until the next accepted `start`.
- `cf_out` out 1: carry register, holding the last bit rotated out (0 for `amt`=0).
- `sh_a` out DATA_W: operand to the shift unit; always equals the internal data register.
- `fbus`, `frbus`, `flbus` out 1 each: shift unit selects; at most one is high in any cycle.
- `sh_w` in DATA_W: shift unit result.
- `sh_cf` in 1: shift unit carry.

## Operation
- States: IDLE, PASS, SHIFT, DONE.
- IDLE:
  - All selects are 0; the shift unit output is Z and is never latched.
  - On `start`=1: load data reg ← `din`, cnt ← `amt`, dir_r ← `dir`.
  - Go to PASS if `amt`=0, else SHIFT.
- PASS:
  - `fbus`=1.
  - At the edge: data ← `sh_w`, cf ← 0. Go to DONE.
- SHIFT:
  - `frbus`=1 if dir_r=0, otherwise `flbus`=1.
  - At each edge: data ← `sh_w`, cf ← `sh_cf`, cnt ← cnt−1.
  - When cnt=1 at the edge, go to DONE; otherwise stay in SHIFT.
- DONE:
  - `done`=1, `busy`=1, selects 0.
  - Next state is always IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `dout` is the data register and `cf_out` is the cf register. Both change only in PASS/SHIFT, so intermediate values are visible while `busy`=1. Consumers qualify the result with `done`.
- Count arithmetic is unsigned AMT_W bits. cnt is never decremented below 1, so there is no wrap.
- Reset (asynchronous, any state, including mid-SHIFT):
  - state → IDLE;
  - data, cnt, dir_r, cf → 0;
  - `busy`=0, `done`=0, `dout`=0, `cf_out`=0, all selects 0.
  - A partially rotated value is discarded.

## Timing
- Moore outputs. Selects and `sh_a` decode from registered state/data only; there are no combinational paths from inputs to outputs.
- The shift unit is combinational. `sh_w`/`sh_cf` are captured in the same cycle the select is driven.
- `start` accepted at edge E0 → `done` high in cycle E0 + max(`amt`,1) + 1. Examples: `amt`=0 or 1 → `done` 2 cycles after `start`; `amt`=7 → 8 cycles.
- Earliest next accepted `start`: the cycle after DONE (back in IDLE). Back-to-back throughput is therefore max(`amt`,1)+2 cycles.
- `start` held high continuously: a new operation is accepted each time the FSM reaches IDLE.

## Structure
- Shared CPU package holds:
  - the state encoding (IDLE=2'd0, PASS=2'd1, SHIFT=2'd2, DONE=2'd3);
  - constants DIR_RIGHT=0 and DIR_LEFT=1;
  - DATA_W=8, shared with the shift unit and ALU.
- No sub-module. The shift unit is instantiated beside this block at datapath level, with `sh_a`→`a`, `sh_w`←`w`, `sh_cf`←`cf`.
- The counter and FSM are inline.

## Test plan
- `din`=0x81, right, `amt`=1: `frbus` high for one cycle; `done` 2 cycles after `start`; `dout`=0xC0, `cf_out`=1.
- `din`=0x96, left, `amt`=3: `flbus` high for 3 cycles; `done` 4 cycles after `start`; `dout`=0xB4, `cf_out`=0.
- `din`=0x5A, `amt`=0: `fbus` high for one cycle; `dout`=0x5A, `cf_out`=0; `done` 2 cycles after `start`.
- `din`=0x01, right, `amt`=7: `dout`=0x02, `cf_out`=0; `done` 8 cycles after `start`; `busy` high for 8 cycles.
- Pulse `start` with `din`=0xFF during SHIFT of a `amt`=5 operation: it is ignored, and the result matches a standalone run; a `start` in the cycle after `done` is accepted.
- Assert `rst` in the 3rd SHIFT cycle of a `amt`=6 operation: all outputs 0 immediately (asynchronous), and no `done` pulse. After release, a new `amt`=2 operation completes normally.
- Throughout every scenario: assertion that at most one select is high in any cycle, and that no select is high in IDLE or DONE.
